// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types, constants and helpers for the DMA channel arbiter.
package dma_pkg;

  // Channel count and index width used by the handshake interface
  localparam int DMA_NUM_CH = 4;
  localparam int DMA_PRIO_W = 2;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } arbState_t;

  // Priority order after reset: field [1:0] holds the highest-priority channel
  localparam logic [7:0] DEFAULT_PRIORITY = 8'b11_10_01_00;

  // Rotate the priority list so the serviced channel drops to lowest priority
  // and the channel after it becomes highest. Every reachable order is a
  // rotation of 0,1,2,3, so shifting the list to start just after 'ch' gives
  // {ch, ch+3, ch+2, ch+1}.
  function automatic logic [7:0] rotateAfter(input logic [7:0] order,
                                             input logic [1:0] ch);
    logic [1:0] pos;
    logic [1:0] src;
    logic [7:0] rot;
    pos = 2'd0;
    rot = '0;
    for (int i = 0; i < 4; i++) begin
      if (order[2*i +: 2] == ch) begin
        pos = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      src = pos + 2'd1 + 2'(i);
      rot[2*i +: 2] = order[2*src +: 2];
    end
    return rot;
  endfunction

  // One-hot acknowledge vector for a channel index
  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge and hold handshake bundle around the DMA arbiter.
// The master side is the arbiter; the slave side is the surrounding
// controller (request sources, command/mask registers, CPU, timing control).
interface dma_priority_arbiter_if;

  // Inputs to the arbiter
  logic [dma_pkg::DMA_NUM_CH-1:0]                  DREQ;
  logic [dma_pkg::DMA_NUM_CH-1:0]                  swRequest;
  logic [dma_pkg::DMA_NUM_CH-1:0]                  channelMask;
  logic                                            priorityType;
  logic                                            controllerDisable;
  logic                                            HLDA;
  logic                                            serviceDone;

  // Outputs from the arbiter
  logic                                            HRQ;
  logic [dma_pkg::DMA_NUM_CH-1:0]                  DACK;
  logic                                            grantValid;
  logic [dma_pkg::DMA_PRIO_W-1:0]                  grantChannel;
  logic [dma_pkg::DMA_NUM_CH*dma_pkg::DMA_PRIO_W-1:0] priorityOrder;

  modport master (
    input  DREQ, swRequest, channelMask, priorityType, controllerDisable,
           HLDA, serviceDone,
    output HRQ, DACK, grantValid, grantChannel, priorityOrder
  );

  modport slave (
    output DREQ, swRequest, channelMask, priorityType, controllerDisable,
           HLDA, serviceDone,
    input  HRQ, DACK, grantValid, grantChannel, priorityOrder
  );

endinterface

// File: rtl/dma_priority_arbiter_resolver.sv
// Combinational winner selection among active channel requests.
// Fixed mode ranks channels 0 > 1 > 2 > 3; rotating mode walks the stored
// priority list from field [1:0] upward.
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int PRIO_W = DMA_PRIO_W
) (
  input  logic [NUM_CH-1:0]        eff_req_i,
  input  logic                     prio_type_i,
  input  logic [NUM_CH*PRIO_W-1:0] prio_order_i,
  output logic [PRIO_W-1:0]        winner_o,
  output logic                     valid_o
);

  // Channel occupying each priority slot, and whether it is requesting
  logic [PRIO_W-1:0] slot_ch [NUM_CH];
  logic [NUM_CH-1:0] slot_hit;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    assign slot_ch[gi]  = prio_type_i ? prio_order_i[gi*PRIO_W +: PRIO_W]
                                      : PRIO_W'(gi);
    assign slot_hit[gi] = eff_req_i[slot_ch[gi]];
  end

  // Scan from the lowest slot upward; later hits are overridden by earlier slots
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        winner_o = slot_ch[i];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and bus-hold sequencer for the 4-channel DMA controller.
// Samples hardware requests, merges mask and software requests, runs the
// HRQ/HLDA handshake, latches one winning channel per transfer and keeps the
// rotating priority order.
module dma_priority_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = DMA_NUM_CH,
  parameter int PRIO_W = DMA_PRIO_W
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_priority_arbiter_if.master bus
);

  // Registered hardware requests (one cycle of latency)
  logic [NUM_CH-1:0]        dreq_q;

  // Sequencer state, latched grant and priority list
  arbState_t                state_q;
  arbState_t                state_d;
  logic [PRIO_W-1:0]        grant_ch_q;
  logic [PRIO_W-1:0]        grant_ch_d;
  logic [NUM_CH*PRIO_W-1:0] prio_order_q;
  logic [NUM_CH*PRIO_W-1:0] prio_order_d;

  // Arbitration inputs/results
  logic [NUM_CH-1:0]        eff_req;
  logic [PRIO_W-1:0]        winner;
  logic                     winner_valid;

  // Masking applies only to hardware requests; software requests always count
  assign eff_req = (dreq_q & ~bus.channelMask) | bus.swRequest;

  dma_priority_resolver #(
    .NUM_CH (NUM_CH),
    .PRIO_W (PRIO_W)
  ) u_resolver (
    .eff_req_i    (eff_req),
    .prio_type_i  (bus.priorityType),
    .prio_order_i (prio_order_q),
    .winner_o     (winner),
    .valid_o      (winner_valid)
  );

  // State, request sample, latched grant and priority order registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_q       <= '0;
      state_q      <= IDLE;
      grant_ch_q   <= '0;
      prio_order_q <= DEFAULT_PRIORITY;
    end else begin
      dreq_q       <= bus.DREQ;
      state_q      <= state_d;
      grant_ch_q   <= grant_ch_d;
      prio_order_q <= prio_order_d;
    end
  end

  // Next-state logic: request hold, grant on HLDA, release on completion
  always_comb begin
    state_d      = state_q;
    grant_ch_d   = grant_ch_q;
    prio_order_d = prio_order_q;
    case (state_q)
      IDLE: begin
        // Disable only blocks starting a new hold request
        if ((|eff_req) && !bus.controllerDisable) begin
          state_d = HOLD_REQ;
        end
      end
      HOLD_REQ: begin
        if (bus.HLDA) begin
          if (winner_valid) begin
            state_d    = GRANT;
            grant_ch_d = winner;
          end else begin
            // Bus handed over but nobody wants it any more
            state_d = RELEASE;
          end
        end else if (!(|eff_req)) begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Completion wins over a simultaneous HLDA drop
        if (bus.serviceDone) begin
          state_d = RELEASE;
          if (bus.priorityType) begin
            prio_order_d = rotateAfter(prio_order_q, grant_ch_q);
          end
        end else if (!bus.HLDA) begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!bus.HLDA) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs follow the registered state so they change one edge after a decision
  always_comb begin
    bus.HRQ           = (state_q == HOLD_REQ) || (state_q == GRANT);
    bus.grantValid    = (state_q == GRANT);
    bus.DACK          = '0;
    bus.grantChannel  = '0;
    bus.priorityOrder = prio_order_q;
    if (state_q == GRANT) begin
      bus.DACK         = onehot4(grant_ch_q);
      bus.grantChannel = grant_ch_q;
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed table, hand-written
// corner sequences and randomized transactions against a list-based model.
module tb_dma_priority_arbiter;
  import dma_pkg::*;

  typedef struct {
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [3:0] sw;
    int         exp_ch;   // -1: no grant expected
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference priority list: m_order[0] is the highest-priority channel
  int m_order [4];

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_order[i] = i;
  endfunction

  // Serviced channel n goes last, n+1 becomes first
  function automatic void model_rotate(input int n);
    for (int i = 0; i < 4; i++) m_order[i] = (n + 1 + i) % 4;
  endfunction

  function automatic int model_pack();
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r | (m_order[i] << (2 * i));
    return r;
  endfunction

  function automatic int model_winner(input logic [3:0] eff, input logic ptype);
    int c;
    for (int i = 0; i < 4; i++) begin
      c = ptype ? m_order[i] : i;
      if (eff[c]) return c;
    end
    return -1;
  endfunction

  // One clock; sample after the edge and check the standing invariants
  task automatic step();
    logic hl;
    hl = bus.HLDA;
    @(posedge CLK);
    #1;
    check("inv_dack_onehot", int'($onehot0(bus.DACK)), 1);
    check("inv_gv_eq_dack", int'(bus.grantValid), int'(|bus.DACK));
    if (bus.DACK != 4'b0000) check("inv_dack_after_hlda", int'(hl), 1);
  endtask

  task automatic wait_hrq(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      step();
      if (bus.HRQ) seen = 1'b1;
    end
  endtask

  task automatic cleanup();
    bus.DREQ = '0; bus.swRequest = '0; bus.HLDA = 1'b0; bus.serviceDone = 1'b0;
    bus.controllerDisable = 1'b0;
    repeat (3) step();
  endtask

  // Full transfer: request, hold, grant, completion, release
  task automatic do_txn(input logic [3:0] dreq, input logic [3:0] mask,
                        input logic [3:0] sw, input logic ptype,
                        input int hdelay, input string tag, output int got_ch);
    logic [3:0] eff;
    int exp_ch;
    bit seen;
    got_ch = -1;
    bus.DREQ = dreq; bus.channelMask = mask; bus.swRequest = sw;
    bus.priorityType = ptype; bus.HLDA = 1'b0; bus.serviceDone = 1'b0;
    eff = (dreq & ~mask) | sw;
    exp_ch = model_winner(eff, ptype);
    wait_hrq(seen);
    check({tag, "_hrq_up"}, int'(seen), int'(eff != 4'b0000));
    if (!seen || eff == 4'b0000) begin
      cleanup();
      return;
    end
    for (int i = 0; i < hdelay; i++) begin
      step();
      check({tag, "_no_dack_wo_hlda"}, int'(bus.DACK), 0);
    end
    bus.HLDA = 1'b1;
    step();
    got_ch = bus.grantValid ? int'(bus.grantChannel) : -1;
    check({tag, "_grant_ch"}, got_ch, exp_ch);
    check({tag, "_dack"}, int'(bus.DACK), 1 << exp_ch);
    check({tag, "_hrq_in_grant"}, int'(bus.HRQ), 1);
    // Request changes mid-service must not disturb the grant
    bus.DREQ = ~dreq; bus.channelMask = ~mask;
    for (int i = 0; i < 2; i++) begin
      step();
      check({tag, "_dack_stable"}, int'(bus.DACK), 1 << exp_ch);
    end
    bus.serviceDone = 1'b1; bus.DREQ = '0; bus.swRequest = '0;
    step();
    bus.serviceDone = 1'b0;
    if (ptype) model_rotate(exp_ch);
    check({tag, "_dack_done"}, int'(bus.DACK), 0);
    check({tag, "_hrq_done"}, int'(bus.HRQ), 0);
    check({tag, "_order"}, int'(bus.priorityOrder), model_pack());
    bus.HLDA = 1'b0;
    step(); step();
    check({tag, "_hrq_idle"}, int'(bus.HRQ), 0);
  endtask

  initial begin
    vec_t tbl [20];
    int   lsb_tab [16];
    int   got;
    bit   seen;
    bit   saw_hrq;
    bit   saw_dack;

    lsb_tab = '{-1, 0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0};
    for (int i = 0; i < 16; i++) tbl[i] = '{4'(i), 4'b0000, 4'b0000, lsb_tab[i]};
    tbl[16] = '{4'b0001, 4'b0001, 4'b0000, -1};
    tbl[17] = '{4'b0001, 4'b0001, 4'b0001,  0};
    tbl[18] = '{4'b1100, 4'b0100, 4'b0000,  3};
    tbl[19] = '{4'b0000, 4'b1111, 4'b1010,  1};

    // Reset with requests and HLDA active
    bus.DREQ = 4'b1111; bus.swRequest = '0; bus.channelMask = '0;
    bus.priorityType = 1'b0; bus.controllerDisable = 1'b0;
    bus.HLDA = 1'b1; bus.serviceDone = 1'b0;
    RESET = 1'b1;
    model_reset();
    step();
    check("reset_hrq", int'(bus.HRQ), 0);
    check("reset_dack", int'(bus.DACK), 0);
    check("reset_gv", int'(bus.grantValid), 0);
    check("reset_gch", int'(bus.grantChannel), 0);
    check("reset_order", int'(bus.priorityOrder), 'hE4);
    step();
    bus.DREQ = '0; bus.HLDA = 1'b0;
    RESET = 1'b0;
    step(); step();

    // Fixed priority, HLDA two cycles after HRQ
    do_txn(4'b0110, 4'b0000, 4'b0000, 1'b0, 2, "fixed0110", got);
    check("fixed0110_ch", got, 1);

    // Directed table in fixed mode
    for (int i = 0; i < 20; i++) begin
      do_txn(tbl[i].dreq, tbl[i].mask, tbl[i].sw, 1'b0, 1, $sformatf("tbl%0d", i), got);
      check($sformatf("tbl%0d_exp", i), got, tbl[i].exp_ch);
    end

    // Rotating priority, all channels requesting
    for (int k = 0; k < 4; k++) begin
      do_txn(4'b1111, 4'b0000, 4'b0000, 1'b1, 1, $sformatf("rot%0d", k), got);
      check($sformatf("rot%0d_ch", k), got, k);
      if (k == 0) check("rot0_order", int'(bus.priorityOrder), 'b00_11_10_01);
    end

    // HLDA abort during a grant on channel 2
    bus.DREQ = 4'b0100; bus.channelMask = '0; bus.priorityType = 1'b1;
    wait_hrq(seen);
    check("abort_hrq_up", int'(seen), 1);
    bus.HLDA = 1'b1;
    step();
    check("abort_grant_ch", int'(bus.grantChannel), 2);
    bus.HLDA = 1'b0; bus.DREQ = '0;
    step();
    check("abort_dack", int'(bus.DACK), 0);
    check("abort_hrq", int'(bus.HRQ), 0);
    check("abort_gv", int'(bus.grantValid), 0);
    check("abort_order", int'(bus.priorityOrder), model_pack());
    cleanup();

    // serviceDone and HLDA drop together: counts as completion
    bus.DREQ = 4'b0010; bus.priorityType = 1'b1;
    wait_hrq(seen);
    check("simul_hrq_up", int'(seen), 1);
    bus.HLDA = 1'b1;
    step();
    check("simul_dack", int'(bus.DACK), 'b0010);
    bus.serviceDone = 1'b1; bus.HLDA = 1'b0; bus.DREQ = '0;
    step();
    bus.serviceDone = 1'b0;
    model_rotate(1);
    check("simul_order", int'(bus.priorityOrder), model_pack());
    check("simul_dack_done", int'(bus.DACK), 0);
    check("simul_hrq_done", int'(bus.HRQ), 0);
    cleanup();

    // Request withdrawn before HLDA
    bus.priorityType = 1'b0;
    saw_hrq = 1'b0; saw_dack = 1'b0;
    bus.DREQ = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) bus.DREQ = '0;
      step();
      if (bus.HRQ) saw_hrq = 1'b1;
      if (bus.DACK != 4'b0000) saw_dack = 1'b1;
    end
    check("withdraw_hrq_rose", int'(saw_hrq), 1);
    check("withdraw_no_dack", int'(saw_dack), 0);
    check("withdraw_hrq_fell", int'(bus.HRQ), 0);
    cleanup();

    // controllerDisable blocks new arbitration
    bus.controllerDisable = 1'b1; bus.DREQ = 4'b1000;
    saw_hrq = 1'b0;
    repeat (5) begin
      step();
      if (bus.HRQ) saw_hrq = 1'b1;
    end
    check("disable_no_hrq", int'(saw_hrq), 0);
    cleanup();

    // controllerDisable does not touch an issued grant
    bus.DREQ = 4'b1000;
    wait_hrq(seen);
    check("dis_grant_hrq_up", int'(seen), 1);
    bus.HLDA = 1'b1;
    step();
    bus.controllerDisable = 1'b1;
    step();
    check("dis_grant_dack", int'(bus.DACK), 'b1000);
    bus.serviceDone = 1'b1; bus.DREQ = '0;
    step();
    bus.serviceDone = 1'b0;
    check("dis_grant_done", int'(bus.DACK), 0);
    cleanup();

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rd, rm, rs;
      logic rp;
      rd = 4'($urandom_range(0, 15));
      rm = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rp = 1'($urandom_range(0, 1));
      do_txn(rd, rm, rs, rp, int'($urandom_range(0, 3)), $sformatf("rnd%0d", t), got);
    end

    // Reset mid-grant with HLDA held high
    bus.DREQ = 4'b1000; bus.priorityType = 1'b1;
    wait_hrq(seen);
    check("rst_mid_hrq_up", int'(seen), 1);
    bus.HLDA = 1'b1;
    step();
    RESET = 1'b1;
    step();
    model_reset();
    check("rst_mid_hrq", int'(bus.HRQ), 0);
    check("rst_mid_dack", int'(bus.DACK), 0);
    check("rst_mid_order", int'(bus.priorityOrder), model_pack());
    RESET = 1'b0;
    cleanup();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
